cgra_col_mem_responder: RTL
===========================

Name: cgra_col_mem_responder

Overview:
- Responder end of one CGRA column data port. Terminates the req/gnt/rvalid protocol issued by a column's reconfigurable cells and serves accesses from a local word-addressed scratchpad.
- Resolves indirect accesses (address from the RC) and direct accesses (internal post-incremented pointer).
- Sits beside the cell array, one instance per column; used as a standalone memory and as a protocol-accurate bench responder with programmable grant latency.

Parameters:
- DEPTH, 256, scratchpad size in 32-bit words; power of two, ≥2.
- DP_WIDTH, cgra_pkg::DP_WIDTH (32), data/address width.
- RC_CONST_WIDTH, cgra_pkg::RC_CONST_WIDTH, width of the signed pointer increment.
- WAIT_W, 4, width of the runtime grant-wait count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  request; held until granted.
- data_wen_i  in  1  1 = read, 0 = write.
- data_ind_i  in  1  1 = indirect (use data_add_i), 0 = direct (use pointer).
- data_add_i  in  DP_WIDTH  byte address for indirect accesses.
- data_wdata_i  in  DP_WIDTH  write data.
- add_inc_i  in  RC_CONST_WIDTH  signed pointer increment in bytes, direct accesses only.
- data_gnt_o  out  1  grant; combinational in the grant cycle.
- data_rvalid_o  out  1  response valid, one cycle after each grant.
- data_rdata_o  out  DP_WIDTH  read data; valid with rvalid on reads.
- err_o  out  1  out-of-range flag, valid with rvalid.
- ptr_we_i  in  1  host load of the direct pointer.
- ptr_wdata_i  in  DP_WIDTH  pointer load value.
- ptr_o  out  DP_WIDTH  current pointer.
- gnt_wait_i  in  WAIT_W  cycles to wait before granting; sampled at request start.

Behaviour:
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, err_o=0, ptr_o=0, FSM=IDLE, wait counter=0. Scratchpad contents are not reset.
- Effective address: data_ind_i ? data_add_i : ptr. Word index = addr[2 +: log2(DEPTH)]. Bits [1:0] are ignored.
- Out of range: addr[DP_WIDTH-1:2] ≥ DEPTH. Read returns 0; write is dropped; err_o=1 with the rvalid.
- FSM IDLE:
  - req=1 and gnt_wait_i=0: gnt=1 in the same cycle; stay IDLE.
  - req=1 and gnt_wait_i=N>0: latch N, cnt←1, go to WAIT; gnt=0.
- FSM WAIT:
  - req=0: abort and go to IDLE. No access, no rvalid, pointer unchanged.
  - cnt==N: gnt=1, go to IDLE.
  - otherwise: cnt←cnt+1.
  - Result: the grant occurs exactly N cycles after the first request cycle.
- Grant cycle effects:
  - Access is performed on the clock edge: write updates the scratchpad; read captures the word into data_rdata_o.
  - Next cycle: data_rvalid_o=1 for one cycle, for reads and writes alike.
  - data_rdata_o holds its value until the next read response; writes do not change it.
- Back-to-back: a new request may be presented the cycle after a grant. With gnt_wait_i=0 it is granted in the same cycle the previous rvalid is high, giving one access per cycle. At most one response is outstanding.
- Pointer:
  - On a direct-access grant, ptr←ptr + sign_extend(add_inc_i), modulo 2^DP_WIDTH. This is a post-increment: the access uses the old ptr.
  - An indirect grant leaves ptr unchanged.
  - If ptr_we_i=1 in the same cycle as a direct grant, the access uses the old ptr and ptr_wdata_i wins over the increment.
- Read-after-write to the same word on consecutive grants returns the new data; no bypass is needed because the write commits on the grant edge.
- Inputs other than data_req_i are sampled only in the grant cycle, so changes during WAIT are legal.
- Asynchronous reset mid-operation: the FSM returns to IDLE; a pending rvalid is cancelled; ptr=0.

Test Plan:
- Write then read, indirect:
  - Stimulus: gnt_wait=0; write 0xDEADBEEF to add 0x10; next cycle read add 0x10.
  - Required: gnt in the request cycle; rvalid the following cycle; read rdata=0xDEADBEEF; err=0.
- Direct pointer stream:
  - Stimulus: load ptr=0x20; four direct writes with add_inc=4 and data 1..4; reload ptr=0x20; four direct reads with add_inc=4.
  - Required: reads return 1,2,3,4; final ptr_o=0x30.
- Negative increment:
  - Stimulus: ptr=0x40; direct read with add_inc=-8.
  - Required: access at word 0x10; ptr_o=0x38.
- Wait and abort:
  - Stimulus: gnt_wait=3, request held.
  - Required: gnt exactly 3 cycles after request start; rvalid one cycle later.
  - Stimulus: repeat, but drop req after 2 cycles.
  - Required: no gnt; no rvalid; ptr unchanged.
- Out of range, DEPTH=256:
  - Stimulus: write 0x55 to add 0x400, then read add 0x400; also read add 0x0.
  - Required: add 0x400 responses have err=1 and read rdata=0; add 0x0 content is unaffected.
- Collision and reset:
  - Stimulus: direct grant with ptr_we=1, ptr_wdata=0x100.
  - Required: ptr_o=0x100 and the access used the old ptr.
  - Stimulus: assert rst_ni low in the cycle after a grant.
  - Required: no rvalid; ptr_o=0.

Source files
------------

// File: rtl/cgra_col_mem_responder.sv
// CGRA column data-port responder: req/gnt/rvalid slave with a local
// word-addressed scratchpad, a post-incremented direct pointer and a
// programmable grant latency.

package cgra_pkg;
  localparam int DP_WIDTH       = 32;
  localparam int RC_CONST_WIDTH = 16;
endpackage

module cgra_col_mem_responder #(
  parameter int DEPTH          = 256,
  parameter int DP_WIDTH       = cgra_pkg::DP_WIDTH,
  parameter int RC_CONST_WIDTH = cgra_pkg::RC_CONST_WIDTH,
  parameter int WAIT_W         = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  input  logic                      data_wen_i,
  input  logic                      data_ind_i,
  input  logic [DP_WIDTH-1:0]       data_add_i,
  input  logic [DP_WIDTH-1:0]       data_wdata_i,
  input  logic [RC_CONST_WIDTH-1:0] add_inc_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DP_WIDTH-1:0]       data_rdata_o,
  output logic                      err_o,
  input  logic                      ptr_we_i,
  input  logic [DP_WIDTH-1:0]       ptr_wdata_i,
  output logic [DP_WIDTH-1:0]       ptr_o,
  input  logic [WAIT_W-1:0]         gnt_wait_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]   n_q, n_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [DP_WIDTH-1:0] rdata_q, rdata_d;
  logic [DP_WIDTH-1:0] ptr_q, ptr_d;
  logic [DP_WIDTH-1:0] mem_q [DEPTH];

  logic                gnt;
  logic [DP_WIDTH-1:0] addr;
  logic [AW-1:0]       idx;
  logic                oor;
  logic [DP_WIDTH-1:0] inc_ext;

  // Direct accesses use the pointer value before this grant's increment.
  assign addr    = data_ind_i ? data_add_i : ptr_q;
  assign idx     = addr[2 +: AW];
  assign oor     = (addr >> (AW + 2)) != '0;
  assign inc_ext = {{(DP_WIDTH-RC_CONST_WIDTH){add_inc_i[RC_CONST_WIDTH-1]}}, add_inc_i};

  // Grant FSM: immediate grant for zero wait, else count up to the latched N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    gnt     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (data_req_i) begin
          if (gnt_wait_i == '0) begin
            gnt = 1'b1;
          end else begin
            n_d     = gnt_wait_i;
            cnt_d   = WAIT_W'(1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!data_req_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == n_q) begin
          gnt     = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response and pointer next-state; host pointer load beats the increment.
  always_comb begin
    rvalid_d = gnt;
    err_d    = gnt & oor;
    rdata_d  = rdata_q;
    ptr_d    = ptr_q;
    if (gnt && data_wen_i) rdata_d = oor ? '0 : mem_q[idx];
    if (ptr_we_i)                 ptr_d = ptr_wdata_i;
    else if (gnt && !data_ind_i)  ptr_d = ptr_q + inc_ext;
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ptr_q    <= ptr_d;
    end
  end

  // Scratchpad write port; contents survive reset, out-of-range writes drop.
  always_ff @(posedge clk_i) begin
    if (gnt && !data_wen_i && !oor) mem_q[idx] <= data_wdata_i;
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign err_o         = err_q;
  assign ptr_o         = ptr_q;

endmodule
